reset_pulse_gen: RTL and testbench

//  Multi-channel edge-to-pulse generator; parametrised successor of the single-channel reset-release pulser.

---
 rtl/neo_io_pkg.sv | 14 +
 rtl/reset_pulse_gen_if.sv | 23 ++
 rtl/reset_pulse_ch.sv | 85 ++++++++
 rtl/reset_pulse_gen.sv | 35 +++
 tb/tb_reset_pulse_gen.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/neo_io_pkg.sv
// Shared I/O-block definitions: per-channel edge-select encodings and the
// pulse-counter width helper.
package neo_io_pkg;

   localparam logic [1:0] EDGE_RISE = 2'b00;
   localparam logic [1:0] EDGE_FALL = 2'b01;
   localparam logic [1:0] EDGE_BOTH = 2'b10;
   localparam logic [1:0] EDGE_OFF  = 2'b11;

   function automatic int cnt_w(input int len);
      return $clog2(len + 1);
   endfunction

endpackage

// File: rtl/reset_pulse_gen_if.sv
// Channel bundle between the board-level level/control signals and the pulse
// generator. All vectors are one bit per channel.
interface reset_pulse_gen_if #(
   parameter int NUM_CH = 4
);
   logic [NUM_CH-1:0] LVL_IN;
   logic [NUM_CH-1:0] MASK;
   logic [NUM_CH-1:0] SW_TRIG;
   logic [NUM_CH-1:0] CLR_STICKY;
   logic [NUM_CH-1:0] nPULSE;
   logic [NUM_CH-1:0] STICKY;

   // LVL_IN is asynchronous; MASK, SW_TRIG and CLR_STICKY are sampled on CLK_24MB.
   modport master (
      output LVL_IN, MASK, SW_TRIG, CLR_STICKY,
      input  nPULSE, STICKY
   );

   modport slave (
      input  LVL_IN, MASK, SW_TRIG, CLR_STICKY,
      output nPULSE, STICKY
   );
endinterface

// File: rtl/reset_pulse_ch.sv
// One channel: level synchroniser, registered edge detect, pulse-length
// counter with registered active-low output, and a sticky trigger flag.
module reset_pulse_ch
   import neo_io_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter int         PULSE_LEN   = 1,
   parameter logic [1:0] EDGE_MODE   = EDGE_RISE,
   parameter int         RETRIGGER   = 1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic lvl_i,
   input  logic mask_i,
   input  logic sw_trig_i,
   input  logic clr_sticky_i,
   output logic npulse_o,
   output logic sticky_o
);

   localparam int            CW   = cnt_w(PULSE_LEN);
   localparam logic [CW-1:0] LOAD = CW'(PULSE_LEN);
   localparam logic [CW-1:0] ONE  = CW'(1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   edge_q, edge_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   npulse_q;
   logic                   sticky_q, sticky_d;
   logic                   lvl_s;
   logic                   trig;
   logic                   accept;

   assign lvl_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      edge_d = 1'b0;
      case (EDGE_MODE)
         EDGE_RISE: edge_d = lvl_s & ~prev_q;
         EDGE_FALL: edge_d = ~lvl_s & prev_q;
         EDGE_BOTH: edge_d = lvl_s ^ prev_q;
         default:   edge_d = 1'b0;
      endcase
   end

   // The mask gates only the trigger; the sync chain keeps tracking so an
   // unmask never releases a stale edge.
   always_comb begin
      trig     = (edge_q & ~mask_i) | sw_trig_i;
      accept   = trig & ((RETRIGGER != 0) || (cnt_q <= ONE));
      cnt_d    = cnt_q;
      if (accept) begin
         cnt_d = LOAD;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - ONE;
      end
      sticky_d = accept | (sticky_q & ~clr_sticky_i);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q   <= '0;
         prev_q   <= 1'b0;
         edge_q   <= 1'b0;
         cnt_q    <= '0;
         npulse_q <= 1'b1;
         sticky_q <= 1'b0;
      end else begin
         sync_q[0] <= lvl_i;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         prev_q   <= lvl_s;
         edge_q   <= edge_d;
         cnt_q    <= cnt_d;
         npulse_q <= (cnt_d == '0);
         sticky_q <= sticky_d;
      end
   end

   assign npulse_o = npulse_q;
   assign sticky_o = sticky_q;

endmodule

// File: rtl/reset_pulse_gen.sv
// Multi-channel edge-to-pulse generator: NUM_CH independent channels, each
// with its own two-bit edge selection taken from EDGE_MODE.
module reset_pulse_gen
   import neo_io_pkg::*;
#(
   parameter int                  NUM_CH      = 4,
   parameter int                  SYNC_STAGES = 2,
   parameter int                  PULSE_LEN   = 1,
   parameter logic [2*NUM_CH-1:0] EDGE_MODE   = '0,
   parameter int                  RETRIGGER   = 1
) (
   input logic               CLK_24MB,
   input logic               RESET,
   reset_pulse_gen_if.slave  io
);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      reset_pulse_ch #(
         .SYNC_STAGES (SYNC_STAGES),
         .PULSE_LEN   (PULSE_LEN),
         .EDGE_MODE   (EDGE_MODE[2*g +: 2]),
         .RETRIGGER   (RETRIGGER)
      ) u_ch (
         .clk_i        (CLK_24MB),
         .rst_i        (RESET),
         .lvl_i        (io.LVL_IN[g]),
         .mask_i       (io.MASK[g]),
         .sw_trig_i    (io.SW_TRIG[g]),
         .clr_sticky_i (io.CLR_STICKY[g]),
         .npulse_o     (io.nPULSE[g]),
         .sticky_o     (io.STICKY[g])
      );
   end

endmodule

// File: tb/tb_reset_pulse_gen.sv
// Bench for reset_pulse_gen: three instances (length 1, length 5 retrigger,
// length 5 no-retrigger) driven with identical stimulus and checked every cycle.
module tb_reset_pulse_gen;

   localparam int NUM_CH = 4;
   localparam int W      = 24;
   // ch3 fall, ch2 both, ch1 disabled, ch0 rise
   localparam logic [7:0] MODES = 8'b01_10_11_00;

   logic clk;
   logic rst;
   logic [NUM_CH-1:0] lvl, msk, sw, clr;

   logic [W-1:0] exp_q[$];
   int n_checks;
   int n_pass;

   reset_pulse_gen_if #(.NUM_CH(NUM_CH)) if1  ();
   reset_pulse_gen_if #(.NUM_CH(NUM_CH)) if5r ();
   reset_pulse_gen_if #(.NUM_CH(NUM_CH)) if5n ();

   assign if1.LVL_IN      = lvl;
   assign if1.MASK        = msk;
   assign if1.SW_TRIG     = sw;
   assign if1.CLR_STICKY  = clr;
   assign if5r.LVL_IN     = lvl;
   assign if5r.MASK       = msk;
   assign if5r.SW_TRIG    = sw;
   assign if5r.CLR_STICKY = clr;
   assign if5n.LVL_IN     = lvl;
   assign if5n.MASK       = msk;
   assign if5n.SW_TRIG    = sw;
   assign if5n.CLR_STICKY = clr;

   reset_pulse_gen #(.NUM_CH(NUM_CH), .SYNC_STAGES(2), .PULSE_LEN(1),
                     .EDGE_MODE(MODES), .RETRIGGER(1))
      dut_1  (.CLK_24MB(clk), .RESET(rst), .io(if1.slave));
   reset_pulse_gen #(.NUM_CH(NUM_CH), .SYNC_STAGES(2), .PULSE_LEN(5),
                     .EDGE_MODE(MODES), .RETRIGGER(1))
      dut_5r (.CLK_24MB(clk), .RESET(rst), .io(if5r.slave));
   reset_pulse_gen #(.NUM_CH(NUM_CH), .SYNC_STAGES(2), .PULSE_LEN(5),
                     .EDGE_MODE(MODES), .RETRIGGER(0))
      dut_5n (.CLK_24MB(clk), .RESET(rst), .io(if5n.slave));

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run still active at %0t, required to finish", $time);
      $fatal(1, "watchdog expired");
   end

   function automatic logic [W-1:0] observed();
      return {if1.nPULSE, if1.STICKY, if5r.nPULSE, if5r.STICKY, if5n.nPULSE, if5n.STICKY};
   endfunction

   // scoreboard pop + compare
   task automatic compare(input string tag);
      logic [W-1:0] exp_v;
      logic [W-1:0] obs_v;
      exp_v = exp_q.pop_front();
      obs_v = observed();
      n_checks++;
      assert (obs_v === exp_v) n_pass = n_pass + 1;
      else $error("FAIL %s: got %h expected %h (np/st len1, len5 retrig, len5 noretrig)",
                  tag, obs_v, exp_v);
   endtask

   // driver: present sw/clr for one edge, expectation is the state after that edge
   task automatic step(input string tag, input logic [3:0] sw_v, input logic [3:0] clr_v,
                       input logic [7:0] e1, input logic [7:0] e5r, input logic [7:0] e5n);
      sw  = sw_v;
      clr = clr_v;
      exp_q.push_back({e1, e5r, e5n});
      @(posedge clk);
      #1;
      compare(tag);
      sw  = '0;
      clr = '0;
   endtask

   task automatic idle(input string tag, input int n,
                       input logic [7:0] e1, input logic [7:0] e5r, input logic [7:0] e5n);
      for (int i = 0; i < n; i++) step(tag, 4'h0, 4'h0, e1, e5r, e5n);
   endtask

   // async assert checked one delta-ish later, release one edge after
   task automatic do_reset(input string tag);
      rst = 1'b1;
      #1;
      exp_q.push_back({8'hF0, 8'hF0, 8'hF0});
      compare(tag);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst = 1'b1;
      lvl = '0;
      msk = '0;
      sw  = '0;
      clr = '0;
      @(posedge clk);
      #1;

      // 1: rising level on ch0 -> pulse three edges after first sample
      do_reset("rst_t1");
      lvl = 4'b0001;
      idle("t1_sync", 3, 8'hF0, 8'hF0, 8'hF0);
      step("t1_load", 4'h0, 4'h0, 8'hE1, 8'hE1, 8'hE1);
      idle("t1_hold", 4, 8'hF1, 8'hE1, 8'hE1);
      step("t1_end", 4'h0, 4'h0, 8'hF1, 8'hF1, 8'hF1);

      // 2: SW_TRIG on ch1 three cycles apart, sticky cleared in between
      lvl = 4'b0000;
      do_reset("rst_t2");
      step("t2_sw0", 4'h2, 4'h0, 8'hD2, 8'hD2, 8'hD2);
      step("t2_clr", 4'h0, 4'h2, 8'hF0, 8'hD0, 8'hD0);
      step("t2_gap", 4'h0, 4'h0, 8'hF0, 8'hD0, 8'hD0);
      step("t2_sw3", 4'h2, 4'h0, 8'hD2, 8'hD2, 8'hD0);
      step("t2_c4", 4'h0, 4'h0, 8'hF2, 8'hD2, 8'hD0);
      idle("t2_tail", 3, 8'hF2, 8'hD2, 8'hF0);
      step("t2_end", 4'h0, 4'h0, 8'hF2, 8'hF2, 8'hF0);

      // 2b: trigger in the last active cycle is accepted even without retrigger
      step("t2b_sw0", 4'h2, 4'h0, 8'hD2, 8'hD2, 8'hD2);
      step("t2b_clr", 4'h0, 4'h2, 8'hF0, 8'hD0, 8'hD0);
      idle("t2b_mid", 3, 8'hF0, 8'hD0, 8'hD0);
      step("t2b_last", 4'h2, 4'h0, 8'hD2, 8'hD2, 8'hD2);
      idle("t2b_hold", 4, 8'hF2, 8'hD2, 8'hD2);
      step("t2b_end", 4'h0, 4'h0, 8'hF2, 8'hF2, 8'hF2);

      // 3: masked rise on both-edge ch2 is swallowed, later fall pulses once
      do_reset("rst_t3");
      msk = 4'b0100;
      lvl = 4'b0100;
      idle("t3_masked", 4, 8'hF0, 8'hF0, 8'hF0);
      msk = 4'b0000;
      idle("t3_unmask", 4, 8'hF0, 8'hF0, 8'hF0);
      lvl = 4'b0000;
      idle("t3_fsync", 3, 8'hF0, 8'hF0, 8'hF0);
      step("t3_fall", 4'h0, 4'h0, 8'hB4, 8'hB4, 8'hB4);
      idle("t3_hold", 4, 8'hF4, 8'hB4, 8'hB4);
      step("t3_end", 4'h0, 4'h0, 8'hF4, 8'hF4, 8'hF4);

      // 4: levels high through reset -> power-up pulse on rise/both channels only
      lvl = 4'b1111;
      do_reset("rst_t4");
      idle("t4_sync", 3, 8'hF0, 8'hF0, 8'hF0);
      step("t4_pup", 4'h0, 4'h0, 8'hA5, 8'hA5, 8'hA5);
      idle("t4_hold", 4, 8'hF5, 8'hA5, 8'hA5);
      step("t4_end", 4'h0, 4'h0, 8'hF5, 8'hF5, 8'hF5);

      // 5: reset in the middle of a long pulse
      lvl = 4'b0000;
      do_reset("rst_t5");
      step("t5_sw", 4'h1, 4'h0, 8'hE1, 8'hE1, 8'hE1);
      idle("t5_run", 2, 8'hF1, 8'hE1, 8'hE1);
      do_reset("t5_midrst");
      idle("t5_quiet", 6, 8'hF0, 8'hF0, 8'hF0);

      // 6: set beats clear in the same cycle; clear alone then wins
      step("t6_setclr", 4'h8, 4'h8, 8'h78, 8'h78, 8'h78);
      step("t6_clr", 4'h0, 4'h8, 8'hF0, 8'h70, 8'h70);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
